// File: rtl/store_buffer_pkg.sv
// Shared MIPS data-memory definitions used by the store buffer slice.
// Holds the dm word-address width, the datapath word width, the default
// store buffer depth and the layout of one buffered store.
package mips_defs;

    localparam int DM_AW    = 10;
    localparam int WORD_W   = 32;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [DM_AW-1:0]  addr;
        logic [WORD_W-1:0] data;
        logic [WORD_W-1:0] pc;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of the datapath store/load signals and the dm port signals seen by
// the store buffer. The slave side is the buffer itself; the master side is
// whatever drives stores/loads and models dm.
interface store_buffer_if;
    import mips_defs::*;

    logic                 st_valid;
    logic [DM_AW+1:2]     st_addr;
    logic [WORD_W-1:0]    st_data;
    logic [WORD_W-1:0]    st_pc;
    logic                 st_ready;

    logic                 ld_req;
    logic [DM_AW+1:2]     ld_addr;
    logic [WORD_W-1:0]    ld_data;
    logic                 ld_stall;

    logic                 mem_write;
    logic [DM_AW+1:2]     mem_addr;
    logic [WORD_W-1:0]    mem_wdata;
    logic [WORD_W-1:0]    mem_pc;
    logic [WORD_W-1:0]    mem_rdata;

    logic                 empty;

    modport slave (
        input  st_valid, st_addr, st_data, st_pc, ld_req, ld_addr, mem_rdata,
        output st_ready, ld_data, ld_stall, mem_write, mem_addr, mem_wdata,
               mem_pc, empty
    );

    modport master (
        output st_valid, st_addr, st_data, st_pc, ld_req, ld_addr, mem_rdata,
        input  st_ready, ld_data, ld_stall, mem_write, mem_addr, mem_wdata,
               mem_pc, empty
    );

endinterface

// File: rtl/sb_match.sv
// Parallel address compare of a load against every valid store buffer entry.
// Reports whether any entry matches and the index of the youngest match, i.e.
// the one closest behind wr_ptr.
module sb_match
    import mips_defs::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                        ld_req,
    input  logic [DM_AW-1:0]            ld_addr,
    input  logic [DEPTH-1:0][DM_AW-1:0] addrs,
    input  logic [PTR_W-1:0]            wr_ptr,
    input  logic [PTR_W:0]              count,
    output logic                        hit,
    output logic [PTR_W-1:0]            hit_idx
);

    logic [PTR_W-1:0] idx;

    // Walk from the oldest valid entry to the youngest so the youngest match is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = wr_ptr - PTR_W'(k + 1);
            if (ld_req && (k < int'(count)) && (addrs[idx] == ld_addr)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Word-granular store buffer between the MIPS datapath and the single-port dm.
// Stores are queued and drained to dm in cycles where no load owns the port.
// Optional macro STORE_BUF_FWD_EN: forward load hits from the youngest
// matching entry; without it a hit stalls the load until the entry drains.
module store_buffer
    import mips_defs::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus
);

    sb_entry_t                   entries [DEPTH];
    logic [DEPTH-1:0][DM_AW-1:0] entry_addrs;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [PTR_W:0]              count;
    sb_entry_t                   head;
    logic                        full;
    logic                        push;
    logic                        drain;
    logic                        hit;
    logic [PTR_W-1:0]            hit_idx;

    // Flatten the stored addresses for the matcher.
    always_comb begin
        entry_addrs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addrs[i] = entries[i].addr;
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .ld_req  (bus.ld_req),
        .ld_addr (bus.ld_addr),
        .addrs   (entry_addrs),
        .wr_ptr  (wr_ptr),
        .count   (count),
        .hit     (hit),
        .hit_idx (hit_idx)
    );

    assign head         = entries[rd_ptr];
    assign full         = (count == (PTR_W + 1)'(DEPTH));
    assign bus.empty    = (count == '0);
    assign bus.st_ready = !full;
    assign push         = bus.st_valid && !full;

`ifdef STORE_BUF_FWD_EN
    assign bus.ld_stall = 1'b0;
    assign bus.ld_data  = hit ? entries[hit_idx].data : bus.mem_rdata;
`else
    logic fwd_unused;
    assign fwd_unused   = ^hit_idx;
    assign bus.ld_stall = hit;
    assign bus.ld_data  = bus.mem_rdata;
`endif

    assign drain = !bus.empty && (!bus.ld_req || bus.ld_stall);

    // The dm port goes to the head store when draining, otherwise to the load.
    always_comb begin
        bus.mem_write = drain;
        bus.mem_addr  = drain ? head.addr : bus.ld_addr;
        bus.mem_wdata = head.data;
        bus.mem_pc    = head.pc;
    end

    // Entry storage is deliberately left uncleared by reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            entries[wr_ptr] <= '{addr: bus.st_addr, data: bus.st_data, pc: bus.st_pc};
        end
    end

    // Pointer and occupancy bookkeeping; reset discards every buffered store.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drain) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a directed vector table, hand-written
// hit and reset sequences, and randomized traffic checked against a queue-based
// reference model plus a behavioural dm. Honours STORE_BUF_FWD_EN.
module tb_store_buffer;
    import mips_defs::*;

    localparam int DEPTH = SB_DEPTH;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } ref_t;

    typedef struct {
        logic        sv;
        logic [9:0]  sa;
        logic [31:0] sd;
        logic        lr;
        logic [9:0]  la;
        logic        e_ready;
        logic        e_empty;
        logic        e_mw;
        logic [9:0]  e_maddr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        dm_clear;
    logic [31:0] env_dm [1024];
    logic [31:0] ref_dm [1024];
    ref_t        refq [$];
    vec_t        vecs [$];

    logic        cur_rst;
    logic        cur_sv;
    logic [9:0]  cur_sa;
    logic [31:0] cur_sd;
    logic [31:0] cur_pc;
    logic        cur_lr;
    logic [9:0]  cur_la;
    logic        m_drain;
    logic        m_push;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    store_buffer_if bus ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mem_rdata = env_dm[bus.mem_addr];

    // Behavioural single-port dm.
    always @(posedge clk) begin
        if (dm_clear) begin
            for (int i = 0; i < 1024; i++) env_dm[i] <= '0;
        end else if (bus.mem_write === 1'b1) begin
            env_dm[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic sv, input logic [9:0] sa,
                                 input logic [31:0] sd, input logic lr, input logic [9:0] la);
        @(negedge clk);
        cur_rst = rst;
        cur_sv  = sv;
        cur_sa  = sa;
        cur_sd  = sd;
        cur_pc  = 32'h0040_0000 | {20'h0, sa, 2'b00};
        cur_lr  = lr;
        cur_la  = la;
        reset        = rst;
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.st_pc    = cur_pc;
        bus.ld_req   = lr;
        bus.ld_addr  = la;
        #1;
    endtask

    // Expected outputs from the buffer rules: FIFO of stores, youngest-hit search, port arbitration.
    task automatic checkModel();
        int          yi;
        logic        hitm;
        logic        stallm;
        logic [31:0] exp_ld;
        yi = -1;
        if (cur_lr) begin
            foreach (refq[i]) if (refq[i].addr == cur_la) yi = i;
        end
        hitm = (yi >= 0);
`ifdef STORE_BUF_FWD_EN
        stallm = 1'b0;
`else
        stallm = hitm;
`endif
        m_drain = (refq.size() > 0) && (!cur_lr || stallm);
        m_push  = cur_sv && (refq.size() < DEPTH);
        checkOutput("st_ready", {31'b0, bus.st_ready}, {31'b0, refq.size() < DEPTH});
        checkOutput("empty", {31'b0, bus.empty}, {31'b0, refq.size() == 0});
        checkOutput("ld_stall", {31'b0, bus.ld_stall}, {31'b0, stallm});
        checkOutput("mem_write", {31'b0, bus.mem_write}, {31'b0, m_drain});
        if (m_drain) begin
            checkOutput("mem_addr_drain", {22'b0, bus.mem_addr}, {22'b0, refq[0].addr});
            checkOutput("mem_wdata", bus.mem_wdata, refq[0].data);
            checkOutput("mem_pc", bus.mem_pc, refq[0].pc);
        end else begin
            checkOutput("mem_addr_load", {22'b0, bus.mem_addr}, {22'b0, cur_la});
        end
        if (cur_lr && !stallm) begin
            exp_ld = ref_dm[cur_la];
            if (hitm) begin
`ifdef STORE_BUF_FWD_EN
                exp_ld = refq[yi].data;
`endif
            end
            checkOutput("ld_data", bus.ld_data, exp_ld);
        end
    endtask

    task automatic finishCycle();
        ref_t e;
        @(posedge clk);
        if (cur_rst) begin
            refq.delete();
        end else begin
            if (m_drain) begin
                ref_dm[refq[0].addr] = refq[0].data;
                void'(refq.pop_front());
            end
            if (m_push) begin
                e.addr = cur_sa;
                e.data = cur_sd;
                e.pc   = cur_pc;
                refq.push_back(e);
            end
        end
    endtask

    task automatic runCycle(input logic rst, input logic sv, input logic [9:0] sa,
                            input logic [31:0] sd, input logic lr, input logic [9:0] la);
        applyStimulus(rst, sv, sa, sd, lr, la);
        if (!rst) checkModel();
        finishCycle();
    endtask

    initial begin
        int bad;
        int n;
        reset        = 1'b1;
        dm_clear     = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_pc    = '0;
        bus.ld_req   = 1'b1;
        bus.ld_addr  = 10'h3F0;
        m_drain      = 1'b0;
        m_push       = 1'b0;
        for (int i = 0; i < 1024; i++) ref_dm[i] = '0;

        runCycle(1'b1, 1'b0, 10'h0, 32'h0, 1'b1, 10'h3F0);
        runCycle(1'b1, 1'b0, 10'h0, 32'h0, 1'b1, 10'h3F0);
        dm_clear = 1'b0;

        // Reset state
        applyStimulus(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 10'h000);
        checkOutput("reset_st_ready", {31'b0, bus.st_ready}, 32'h1);
        checkOutput("reset_empty", {31'b0, bus.empty}, 32'h1);
        checkOutput("reset_mem_write", {31'b0, bus.mem_write}, 32'h0);
        checkOutput("reset_ld_stall", {31'b0, bus.ld_stall}, 32'h0);
        checkModel();
        finishCycle();

        // Directed table: single store, then fill/stall, held store, drain in order with wrap
        vecs.push_back('{1'b1, 10'h004, 32'h1234_5678, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h000});
        vecs.push_back('{1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h004});
        vecs.push_back('{1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h000});
        vecs.push_back('{1'b1, 10'h100, 32'hA000_0001, 1'b1, 10'h3F0, 1'b1, 1'b1, 1'b0, 10'h3F0});
        vecs.push_back('{1'b1, 10'h101, 32'hA000_0002, 1'b1, 10'h3F0, 1'b1, 1'b0, 1'b0, 10'h3F0});
        vecs.push_back('{1'b1, 10'h102, 32'hA000_0003, 1'b1, 10'h3F0, 1'b1, 1'b0, 1'b0, 10'h3F0});
        vecs.push_back('{1'b1, 10'h103, 32'hA000_0004, 1'b1, 10'h3F0, 1'b1, 1'b0, 1'b0, 10'h3F0});
        vecs.push_back('{1'b1, 10'h104, 32'hA000_0005, 1'b1, 10'h3F0, 1'b0, 1'b0, 1'b0, 10'h3F0});
        vecs.push_back('{1'b1, 10'h104, 32'hA000_0005, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h100});
        vecs.push_back('{1'b1, 10'h104, 32'hA000_0005, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h101});
        vecs.push_back('{1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h102});
        vecs.push_back('{1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h103});
        vecs.push_back('{1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h104});
        vecs.push_back('{1'b0, 10'h000, 32'h0,         1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h000});
        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].lr, vecs[i].la);
            checkOutput($sformatf("vec%0d_st_ready", i), {31'b0, bus.st_ready}, {31'b0, vecs[i].e_ready});
            checkOutput($sformatf("vec%0d_empty", i), {31'b0, bus.empty}, {31'b0, vecs[i].e_empty});
            checkOutput($sformatf("vec%0d_mem_write", i), {31'b0, bus.mem_write}, {31'b0, vecs[i].e_mw});
            checkOutput($sformatf("vec%0d_mem_addr", i), {22'b0, bus.mem_addr}, {22'b0, vecs[i].e_maddr});
            checkModel();
            finishCycle();
        end
        #1;
        checkOutput("dm_word_004", env_dm[10'h004], 32'h1234_5678);
        checkOutput("dm_word_100", env_dm[10'h100], 32'hA000_0001);
        checkOutput("dm_word_104", env_dm[10'h104], 32'hA000_0005);

        // Two stores to the same word, then a load of it
        runCycle(1'b0, 1'b1, 10'h010, 32'hAAAA_AAAA, 1'b1, 10'h3F0);
        runCycle(1'b0, 1'b1, 10'h010, 32'hBBBB_BBBB, 1'b1, 10'h3F0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 10'h010);
`ifdef STORE_BUF_FWD_EN
            checkOutput($sformatf("fwd%0d_ld_data", c), bus.ld_data, 32'hBBBB_BBBB);
            checkOutput($sformatf("fwd%0d_ld_stall", c), {31'b0, bus.ld_stall}, 32'h0);
            checkOutput($sformatf("fwd%0d_mem_write", c), {31'b0, bus.mem_write}, 32'h0);
`else
            if (c < 2) begin
                checkOutput($sformatf("stall%0d_ld_stall", c), {31'b0, bus.ld_stall}, 32'h1);
                checkOutput($sformatf("stall%0d_mem_wdata", c), bus.mem_wdata,
                            (c == 0) ? 32'hAAAA_AAAA : 32'hBBBB_BBBB);
            end else begin
                checkOutput("stall_done_ld_stall", {31'b0, bus.ld_stall}, 32'h0);
                checkOutput("stall_done_ld_data", bus.ld_data, 32'hBBBB_BBBB);
            end
`endif
            checkModel();
            finishCycle();
        end
        for (int c = 0; c < 3; c++) runCycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 10'h000);
        #1;
        checkOutput("dm_word_010", env_dm[10'h010], 32'hBBBB_BBBB);

        // Reset with three stores buffered
        runCycle(1'b0, 1'b1, 10'h200, 32'hDEAD_0000, 1'b1, 10'h3F0);
        runCycle(1'b0, 1'b1, 10'h201, 32'hDEAD_0001, 1'b1, 10'h3F0);
        runCycle(1'b0, 1'b1, 10'h202, 32'hDEAD_0002, 1'b1, 10'h3F0);
        runCycle(1'b1, 1'b0, 10'h0, 32'h0, 1'b1, 10'h3F0);
        applyStimulus(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 10'h000);
        checkOutput("midreset_empty", {31'b0, bus.empty}, 32'h1);
        checkOutput("midreset_mem_write", {31'b0, bus.mem_write}, 32'h0);
        checkModel();
        finishCycle();
        for (int c = 0; c < 3; c++) runCycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 10'h000);
        #1;
        checkOutput("midreset_dm_200", env_dm[10'h200], 32'h0);
        checkOutput("midreset_dm_202", env_dm[10'h202], 32'h0);

        // Randomized traffic over a small address window so hits are frequent
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                runCycle(1'b1, 1'b0, 10'h0, 32'h0, 1'b1, 10'h3FF);
            end else begin
                runCycle(1'b0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom(),
                         1'($urandom_range(0, 9) < 6), 10'($urandom_range(0, 15)));
            end
        end

        // Drain everything and compare the whole dm image
        n = 0;
        while (bus.empty !== 1'b1 && n < 20) begin
            runCycle(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 10'h000);
            n++;
        end
        #1;
        checkOutput("final_empty", {31'b0, bus.empty}, 32'h1);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (env_dm[i] !== ref_dm[i]) bad++;
        checkOutput("dm_final_bad_words", 32'(bad), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Word-granular write buffer between the MIPS datapath and data memory `dm`. `dm` has one address port that serves both the read and the write, so a load and a store cannot both use it in the same cycle. This block queues stores in a small FIFO and drains them to `dm` in cycles where no load needs the port. Loads always get the port; a load that hits a buffered word is either forwarded from the buffer or stalled, depending on build configuration.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of 2, at least 2.
- `PTR_W`, 2: log2(`DEPTH`).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `st_valid`  in  1  store request from the datapath.
- `st_addr`  in  [11:2]  store word address.
- `st_data`  in  32  store data.
- `st_pc`  in  32  PC of the store instruction, carried through for the write trace.
- `st_ready`  out  1  buffer can accept a store; equals !full.
- `ld_req`  in  1  load in this cycle.
- `ld_addr`  in  [11:2]  load word address.
- `ld_data`  out  32  load result.
- `ld_stall`  out  1  load cannot complete this cycle; the datapath holds the load.
- `mem_write`  out  1  to `dm` MemWrite.
- `mem_addr`  out  [11:2]  to `dm` MemAddr.
- `mem_wdata`  out  32  to `dm` MemData.
- `mem_pc`  out  32  to `dm` PC.
- `mem_rdata`  in  32  from `dm` dout.
- `empty`  out  1  no buffered stores; the datapath uses it to fence (e.g. before syscall or halt).

## Operation
- **FIFO state:**
  - `wr_ptr` and `rd_ptr` are `PTR_W` bits wide and wrap modulo `DEPTH`.
  - `count` is `PTR_W+1` bits wide, range 0..`DEPTH`.
  - Each entry holds {addr, data, pc}.
- **Push:** `st_valid && st_ready`.
  - The entry is written at `wr_ptr` and `wr_ptr` increments.
- **Hit detection:** `hit` = `ld_req` and some valid entry has addr == `ld_addr`.
  - Only entries already present before this cycle are searched.
  - A store pushed in the same cycle is not visible to the load.
- **Drain:** `drain` = !empty && (!`ld_req` || `ld_stall`).
  - When `drain` is high: `mem_write`=1, `mem_addr`/`mem_wdata`/`mem_pc` = head entry, and `rd_ptr` increments at the clock edge.
  - Otherwise: `mem_write`=0, `mem_addr`=`ld_addr`, and `mem_wdata`/`mem_pc` = head fields (don't-care).
- **Count update:**
  - Push and drain in the same cycle: `count` unchanged.
  - Push only: +1.
  - Drain only: −1.
- **Load data:** `ld_data` = forwarded data on a forwarded hit, else `mem_rdata`.
- **Full:** `st_ready`=0. A store held by the datapath is accepted on the first cycle after a drain frees an entry.
- **Reset:**
  - Pointers and `count` clear to 0; all buffered stores are discarded.
  - Entry storage is not cleared.
- **Outputs after reset:** `st_ready`=1, `empty`=1, `mem_write`=0, `ld_stall`=0.

## Timing
- **Store:** accepted at edge k; it can drive `mem_write` in cycle k+1 and `dm` is written at edge k+1 if no load claims the port.
- **Load, no hit:** zero added latency; `ld_data` is combinational from `mem_rdata` in the same cycle.
- **Forwarded hit:** zero latency, `ld_stall`=0, and no drain that cycle.
- **Stalled hit:** `ld_stall`=1 while any matching entry remains. The port is given to the drain, so at most one entry drains per stalled cycle and the worst-case stall is `DEPTH` cycles.
- **Write order:** writes reach `dm` strictly in push order, one per cycle at most.
- **Back-to-back loads:** continuous `ld_req` with no hits blocks draining indefinitely. The datapath guarantees progress by fencing on `empty`.

## Configuration
- `STORE_BUF_FWD_EN` defined:
  - Hits are forwarded from the youngest matching entry (the last written before `wr_ptr`).
  - `ld_stall` is constant 0.
- `STORE_BUF_FWD_EN` undefined:
  - No forwarding path exists; every hit asserts `ld_stall`.
  - `ld_data` is always `mem_rdata`.

## Structure
- Shared package `mips_defs` holds:
  - `DM_AW` = 10 (word-address width),
  - `WORD_W` = 32,
  - the default `DEPTH`.
- Sub-module `sb_match`: parallel address compare over all valid entries.
  - Outputs `hit` and the youngest matching index, using an age priority search from `wr_ptr−1` back toward `rd_ptr`.
  - Shared by both configurations; the forwarding mux is compiled only under `STORE_BUF_FWD_EN`.

## Test plan
- **Reset, then single store:** store addr 0x004, data 0x1234_5678 with `ld_req`=0.
  - The next cycle drives `mem_write`=1, `mem_addr`=0x004.
  - After that edge, `empty`=1 and `dm` word 4 holds 0x12345678.
- **Fill and stall:** push 4 stores with `ld_req` held high and no hits.
  - `st_ready`=0 after the fourth push.
  - A 5th store is held until `ld_req` drops; then one drain per cycle, in FIFO order.
- **Youngest hit, with forwarding:** buffer holds addr 0x010 = 0xAAAA_AAAA, then 0x010 = 0xBBBB_BBBB; load 0x010.
  - `ld_data`=0xBBBBBBBB, `ld_stall`=0, no drain that cycle.
- **Same scenario, without forwarding:**
  - `ld_stall`=1 for 2 cycles while both entries drain.
  - Then `ld_data`=0xBBBBBBBB from `dm`.
- **Simultaneous push and drain at count 4:**
  - Store accepted only after a drain edge; `count` never exceeds 4.
  - Pointer wrap from 3 to 0 preserves order.
- **Reset mid-operation:** assert `reset` with 3 entries buffered.
  - Next cycle: `empty`=1, `mem_write`=0, and `dm` is unchanged by the discarded entries.
